// File: rtl/vga_sink_monitor.sv
// Passive VGA sink: recovers pixel phase and x/y from hsync/vsync, checks sync timing, checksums frames.
// Latency: pins -> edge detect 2 clk; pixel strobe outputs registered one clk after the mid-pixel phase.
// Backpressure: none; pure observer, every input sample is consumed, outputs are strobes/levels.
module vga_sink_monitor #(
    parameter int CLK_DIV      = 4,
    parameter int H_ACTIVE     = 640,
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_W     = 96,
    parameter int V_ACTIVE     = 480,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_W     = 2,
    parameter bit SYNC_POL     = 1'b1,
    parameter int PIX_SKEW     = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        pix_valid,
    output logic        de,
    output logic [11:0] pix_rgb,
    output logic        locked,
    output logic        sync_err,
    output logic [7:0]  err_cnt,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [15:0] frame_cnt
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_STB  = PW'(CLK_DIV / 2);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] HTOT   = 10'(H_TOTAL);
    localparam logic [9:0] HSS    = 10'(H_SYNC_START);
    localparam logic [9:0] HSE    = 10'((H_SYNC_START + H_SYNC_W) % H_TOTAL);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] VSS    = 10'(V_SYNC_START);
    localparam logic [9:0] VSE    = 10'((V_SYNC_START + V_SYNC_W) % V_TOTAL);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] SKEW   = 10'(PIX_SKEW);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e          state_q;
    logic            train_bad_q;

    logic            hs_q, vs_q, hs_p_q, vs_p_q;
    logic [11:0]     rgb_q;

    logic [PW-1:0]   phase_q, phase_d, ph_fr;
    logic [9:0]      h_q, h_d, h_fr;
    logic [9:0]      v_q, v_d, v_fr;
    logic            ph_wrap, h_wrap;

    logic            hs_on, hs_was, vs_on, vs_was;
    logic            hs_lead, hs_trail, vs_lead, vs_trail;
    logic            bad_edge, viol, strobe, lock_gain, frame_end;
    logic [9:0]      x_new;

    logic [9:0]      x_q, y_q;
    logic            pix_valid_q, de_q, locked_q, sync_err_q, frame_done_q;
    logic [11:0]     pix_rgb_q;
    logic [7:0]      err_cnt_q;
    logic [15:0]     acc_q, acc_add, frame_sum_q, frame_cnt_q;

    // Capture the pins once, keep one delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q   <= ~SYNC_POL;
            vs_q   <= ~SYNC_POL;
            hs_p_q <= ~SYNC_POL;
            vs_p_q <= ~SYNC_POL;
            rgb_q  <= '0;
        end else begin
            hs_q   <= hsync;
            vs_q   <= vsync;
            hs_p_q <= hs_q;
            vs_p_q <= vs_q;
            rgb_q  <= rgb;
        end
    end

    assign hs_on    = (hs_q   == SYNC_POL);
    assign hs_was   = (hs_p_q == SYNC_POL);
    assign vs_on    = (vs_q   == SYNC_POL);
    assign vs_was   = (vs_p_q == SYNC_POL);
    assign hs_lead  = hs_on  & ~hs_was;
    assign hs_trail = ~hs_on &  hs_was;
    assign vs_lead  = vs_on  & ~vs_was;
    assign vs_trail = ~vs_on &  vs_was;

    // Free-running counter advance, sync reloads, and timing checks against the free-run values.
    // The checks compare what the counters would have become without the reload, so an aligned
    // source makes every reload a no-op.
    always_comb begin
        ph_wrap = (phase_q == PH_LAST);
        ph_fr   = ph_wrap ? '0 : phase_q + 1'b1;
        h_wrap  = ph_wrap && (h_q == H_LAST);
        h_fr    = h_q;
        if (ph_wrap) h_fr = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
        v_fr    = v_q;
        if (h_wrap) v_fr = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;

        phase_d = hs_lead ? '0  : ph_fr;
        h_d     = hs_lead ? HSS : h_fr;
        v_d     = vs_lead ? VSS : v_fr;

        bad_edge = (hs_lead  && ((h_fr != HSS) || (ph_fr != '0)))
                || (hs_trail && ((h_fr != HSE) || (ph_fr != '0)))
                || (vs_lead  && ((v_fr != VSS) || (h_fr != HSS)))
                || (vs_trail &&  (v_fr != VSE));
        viol      = bad_edge && (state_q != ST_SEARCH);
        strobe    = (phase_q == PH_STB);
        lock_gain = (state_q == ST_TRAIN) && vs_lead && !train_bad_q && !viol;
        frame_end = (state_q == ST_LOCKED) && vs_lead && !viol;
        x_new     = (h_q >= SKEW) ? (h_q - SKEW) : (h_q + HTOT - SKEW);
        acc_add   = acc_q + ((pix_valid_q && de_q) ? {4'h0, pix_rgb_q} : 16'h0000);
    end

    // Pixel phase and h/v position counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            phase_q <= phase_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    // Lock FSM with its registered status and pixel outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_SEARCH;
            train_bad_q <= 1'b0;
            locked_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            de_q        <= 1'b0;
            pix_rgb_q   <= '0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            if (strobe) begin
                x_q <= x_new;
                y_q <= v_q;
            end
            pix_valid_q <= 1'b0;
            de_q        <= 1'b0;
            case (state_q)
                ST_SEARCH: begin
                    if (vs_lead) begin
                        state_q     <= ST_TRAIN;
                        train_bad_q <= 1'b0;
                    end
                end
                ST_TRAIN: begin
                    if (viol) train_bad_q <= 1'b1;
                    if (vs_lead) begin
                        train_bad_q <= 1'b0;
                        if (lock_gain) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (viol) begin
                        state_q  <= ST_SEARCH;
                        locked_q <= 1'b0;
                    end else if (strobe) begin
                        pix_valid_q <= 1'b1;
                        de_q        <= (x_new < H_ACT) && (v_q < V_ACT);
                        pix_rgb_q   <= rgb_q;
                    end
                end
                default: begin
                    state_q  <= ST_SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // Violation pulse and saturating error count; coincident failures count once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            sync_err_q <= viol;
            if (viol && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    // Frame checksum: cleared on lock gain so a partially observed frame never reports.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q        <= '0;
            frame_sum_q  <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            if (lock_gain) begin
                acc_q <= '0;
            end else if (frame_end) begin
                frame_sum_q <= acc_add;
                frame_cnt_q <= frame_cnt_q + 16'd1;
                acc_q       <= '0;
            end else begin
                acc_q <= acc_add;
            end
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign pix_valid  = pix_valid_q;
    assign de         = de_q;
    assign pix_rgb    = pix_rgb_q;
    assign locked     = locked_q;
    assign sync_err   = sync_err_q;
    assign err_cnt    = err_cnt_q;
    assign frame_done = frame_done_q;
    assign frame_sum  = frame_sum_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_sink_monitor.sv
// Directed bench for vga_sink_monitor on a shrunken raster (16x10 pixels, 8x6 active, 4 clk/pixel).
// Latency: stimulus is driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: none; the generator free-runs and the monitor only observes.
module tb_vga_sink_monitor;

    localparam int CD  = 4;
    localparam int HA  = 8;
    localparam int HT  = 16;
    localparam int HSS = 10;
    localparam int HSW = 3;
    localparam int VA  = 6;
    localparam int VT  = 10;
    localparam int VSS = 7;
    localparam int VSW = 2;
    localparam int FR  = CD * HT * VT;
    localparam int LN  = CD * HT;

    logic        clk;
    logic        reset_n;
    logic        hsync, vsync;
    logic [11:0] rgb;
    logic [9:0]  x, y;
    logic        pix_valid, de, locked, sync_err, frame_done;
    logic [11:0] pix_rgb;
    logic [7:0]  err_cnt;
    logic [15:0] frame_sum, frame_cnt;

    vga_sink_monitor #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_W(HSW),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_W(VSW),
        .SYNC_POL(1'b1), .PIX_SKEW(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .x(x), .y(y), .pix_valid(pix_valid), .de(de), .pix_rgb(pix_rgb),
        .locked(locked), .sync_err(sync_err), .err_cnt(err_cnt),
        .frame_done(frame_done), .frame_sum(frame_sum), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int n_err = 0;
    int n_fd  = 0;
    logic [11:0] rgb00 = 12'hFFF;
    bit mode = 1'b0;

    int gv = 0, gh = 0, gp = 0, line_abs = 0;
    int inj_line = -1, inj_lead = 0, inj_trail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] model(input logic [9:0] xx);
        return mode ? {2'b00, xx} : 12'h0FF;
    endfunction

    // One system clock of ideal 1-pixel-skewed VGA, with optional edge offsets on one line.
    task automatic step();
        int lc, pos, lo, to;
        lo = 0;
        to = 0;
        if (line_abs == inj_line) begin
            lo = inj_lead;
            to = inj_trail;
        end
        lc  = gh * CD + gp;
        pos = gv * HT * CD + lc;
        hsync = (lc >= HSS * CD + lo) && (lc < (HSS + HSW) * CD + to);
        vsync = (pos >= (VSS * HT + HSS) * CD) && (pos < ((VSS + VSW) * HT + HSS) * CD);
        if (gh >= 1 && gh <= HA && gv < VA) rgb = model(10'(gh - 1));
        else rgb = 12'h000;
        @(posedge clk);
        #1;
        gp++;
        if (gp == CD) begin
            gp = 0;
            gh++;
            if (gh == HT) begin
                gh = 0;
                line_abs++;
                gv++;
                if (gv == VT) gv = 0;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Output monitor: pulse counters and per-pixel colour check while locked.
    always @(negedge clk) begin
        if (reset_n) begin
            if (sync_err) n_err++;
            if (frame_done) n_fd++;
            if (pix_valid && de) begin
                chk("pix", 32'(pix_rgb), 32'(model(x)));
                if (x == 10'd0 && y == 10'd0) rgb00 = pix_rgb;
            end
        end
    end

    initial begin
        int base;
        reset_n = 1'b0;
        hsync   = 1'b0;
        vsync   = 1'b0;
        rgb     = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_pv", 32'(pix_valid), 0);
        chk("rst_xy", 32'({x, y}), 0);
        chk("rst_err", 32'({sync_err, err_cnt}), 0);
        chk("rst_frame", 32'({frame_done, frame_sum}), 0);
        chk("rst_fcnt", 32'(frame_cnt), 0);
        reset_n = 1'b1;

        // Ideal timing, constant colour: lock at 2nd vsync, first report at 3rd.
        mode = 1'b0;
        run(FR);
        chk("f0_locked", 32'(locked), 0);
        run(FR);
        chk("f1_locked", 32'(locked), 1);
        chk("f1_fd", n_fd, 0);
        run(FR);
        chk("f2_fd", n_fd, 1);
        chk("f2_sum", 32'(frame_sum), 32'h2FD0);
        chk("f2_fcnt", 32'(frame_cnt), 1);
        chk("f2_nerr", n_err, 0);
        chk("f2_errcnt", 32'(err_cnt), 0);

        // One hsync pulse one pixel short.
        inj_line = line_abs + 2; inj_lead = 0; inj_trail = -CD;
        run(FR);
        chk("short_nerr", n_err, 1);
        chk("short_errcnt", 32'(err_cnt), 1);
        chk("short_locked", 32'(locked), 0);
        chk("short_sum_hold", 32'(frame_sum), 32'h2FD0);
        chk("short_fcnt", 32'(frame_cnt), 1);
        run(FR);
        chk("short_relock", 32'(locked), 1);

        // Hsync leading edge one clk late: phase error.
        inj_line = line_abs + 2; inj_lead = 1; inj_trail = 0;
        run(3 * LN);
        chk("phase_nerr", n_err, 2);
        chk("phase_errcnt", 32'(err_cnt), 2);
        chk("phase_locked", 32'(locked), 0);
        run(FR - 3 * LN);
        run(FR);
        chk("phase_relock", 32'(locked), 1);

        // Gradient frame.
        mode = 1'b1;
        rgb00 = 12'hFFF;
        run(FR);
        chk("grad_sum", 32'(frame_sum), 32'h00A8);
        chk("grad_fcnt", 32'(frame_cnt), 2);
        chk("grad_fd", n_fd, 2);
        chk("grad_rgb00", 32'(rgb00), 0);

        // Reset mid-frame while locked.
        mode = 1'b0;
        run(3 * LN);
        chk("pre_rst_locked", 32'(locked), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_locked", 32'(locked), 0);
        chk("mid_rst_fcnt", 32'(frame_cnt), 0);
        chk("mid_rst_sum", 32'(frame_sum), 0);
        chk("mid_rst_err", 32'(err_cnt), 0);
        chk("mid_rst_pv", 32'({pix_valid, de}), 0);
        reset_n = 1'b1;
        run(FR - 3 * LN);
        chk("rst_f0_locked", 32'(locked), 0);
        run(FR);
        chk("rst_f1_locked", 32'(locked), 1);
        run(FR);
        chk("rst_fcnt_restart", 32'(frame_cnt), 1);
        chk("rst_sum", 32'(frame_sum), 32'h2FD0);

        // Garbage syncs: errors pile up in TRAIN until the count saturates.
        for (int i = 0; i < 1000; i++) begin
            hsync = i[1];
            vsync = i[3];
            rgb   = 12'h000;
            @(posedge clk);
            #1;
        end
        chk("sat_errcnt", 32'(err_cnt), 255);
        chk("sat_locked", 32'(locked), 0);
        chk("sat_many", 32'(n_err > 300), 1);

        // Both syncs stuck asserted: no edges, so no further errors and no frames.
        hsync = 1'b1;
        vsync = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        base = n_err;
        repeat (400) @(posedge clk);
        #1;
        chk("stuck_noerr", n_err - base, 0);
        chk("stuck_fcnt", 32'(frame_cnt), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
